// File: rtl/top_counter_pkg.sv
// rtl/top_counter_pkg.sv - shared constants and helpers for the counter board test
//
// Purpose: default parameter values for top_counter and the prescaler width helper.
// Contents:
//   COUNTER_WIDTH_DEF    default counter/led width
//   COUNTER_INIT_DEF     default power-up/reset count
//   COUNTER_PRESCALE_DEF default clock cycles per count step
//   prescale_width()     bits needed for a 0..PRESCALE-1 counter, at least 1
package top_counter_pkg;

  localparam int COUNTER_WIDTH_DEF    = 4;
  localparam int COUNTER_INIT_DEF     = 0;
  localparam int COUNTER_PRESCALE_DEF = 1;

  // clog2(p) with a floor of 1 so a PRESCALE of 1 or 2 still yields a legal vector.
  function automatic int prescale_width(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/top_counter_if.sv
// rtl/top_counter_if.sv - LED bank bundle for the counter board test
//
// Purpose: groups the counter's board-facing signals for benches and wrappers.
// Signals:
//   led  WIDTH  current count value
//   dir  1      count direction (only with TOP_COUNTER_DIR_EN)
// Modports:
//   master  the counter side (drives led, reads dir)
//   slave   the board/bench side (reads led, drives dir)
// Optional feature macro: TOP_COUNTER_DIR_EN
interface top_counter_if #(
  parameter int WIDTH = top_counter_pkg::COUNTER_WIDTH_DEF
);

  logic [WIDTH-1:0] led;
`ifdef TOP_COUNTER_DIR_EN
  logic             dir;

  modport master (output led, input dir);
  modport slave  (input led, output dir);
`else
  modport master (output led);
  modport slave  (input led);
`endif

endinterface

// File: rtl/top_counter_tick.sv
// rtl/top_counter_tick.sv - prescaler producing one count step every PRESCALE clocks
//
// Purpose: divides clk into a one-cycle step strobe.
// Ports:
//   clk   input   system clock
//   rst   input   asynchronous active-high reset, clears the prescaler to 0
//   tick  output  high for one cycle every PRESCALE cycles; constant 1 when PRESCALE=1
module top_counter_tick
  import top_counter_pkg::*;
#(
  parameter int PRESCALE = COUNTER_PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_no_prescale
      // Every edge is a step; no state needed.
      logic unused_ok;
      assign unused_ok = clk | rst;
      assign tick      = 1'b1;
    end else begin : g_prescale
      localparam int             PW   = prescale_width(PRESCALE);
      localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);
      localparam logic [PW-1:0]  ONE  = PW'(1);

      // Power-up value lets the board run with rst tied low.
      logic [PW-1:0] pre_q = '0;
      logic [PW-1:0] pre_d;

      assign tick = (pre_q == LAST);

      always_comb begin
        pre_d = tick ? '0 : pre_q + ONE;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/top_counter.sv
// rtl/top_counter.sv - free-running LED counter, top of the counter board test
//
// Purpose: binary counter stepping every PRESCALE clocks, count shown directly on led.
// Ports:
//   clk  input   system clock
//   rst  input   asynchronous active-high reset, forces count to INIT
//   dir  input   0 = count up, 1 = count down (only with TOP_COUNTER_DIR_EN)
//   led  output  count register, no output logic
// Optional feature macro: TOP_COUNTER_DIR_EN
module top_counter
  import top_counter_pkg::*;
#(
  parameter int WIDTH    = COUNTER_WIDTH_DEF,
  parameter int INIT     = COUNTER_INIT_DEF,
  parameter int PRESCALE = COUNTER_PRESCALE_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef TOP_COUNTER_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] led
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic             tick;
  // Power-up value lets the board run with rst tied low.
  logic [WIDTH-1:0] count_q = INIT_V;
  logic [WIDTH-1:0] count_d;

  top_counter_tick #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Wrap in either direction is plain modulo arithmetic.
  always_comb begin
    count_d = count_q;
    if (tick) begin
`ifdef TOP_COUNTER_DIR_EN
      count_d = dir ? (count_q - ONE) : (count_q + ONE);
`else
      count_d = count_q + ONE;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= INIT_V;
    end else begin
      count_q <= count_d;
    end
  end

  assign led = count_q;

endmodule

// File: tb/tb_top_counter.sv
// tb/tb_top_counter.sv - self-checking bench for top_counter (default and PRESCALE=3/INIT=5)
`timescale 1ns/1ps
module tb_top_counter;

  localparam int W      = 4;
  localparam int MODV   = 16;
  localparam int INIT_A = 0;
  localparam int INIT_B = 5;
  localparam int PRE_B  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model: edges counted since the last reset release, value per DUT.
  int n_edges = 0;
  int va      = INIT_A;
  int vb      = INIT_B;

  top_counter_if #(.WIDTH(W)) bus_a ();
  top_counter_if #(.WIDTH(W)) bus_b ();

  top_counter dut_a (
    .clk (clk),
    .rst (rst),
`ifdef TOP_COUNTER_DIR_EN
    .dir (bus_a.dir),
`endif
    .led (bus_a.led)
  );

  top_counter #(
    .WIDTH    (W),
    .INIT     (INIT_B),
    .PRESCALE (PRE_B)
  ) dut_b (
    .clk (clk),
    .rst (rst),
`ifdef TOP_COUNTER_DIR_EN
    .dir (bus_b.dir),
`endif
    .led (bus_b.led)
  );

  always #100 clk = ~clk;

  function automatic int cur_step();
`ifdef TOP_COUNTER_DIR_EN
    return bus_a.dir ? -1 : 1;
`else
    return 1;
`endif
  endfunction

  task automatic set_dir(input logic d);
`ifdef TOP_COUNTER_DIR_EN
    bus_a.dir = d;
    bus_b.dir = d;
`else
    if (d) $display("note: dir ignored without TOP_COUNTER_DIR_EN");
`endif
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input int exp);
    logic [W-1:0] e;
    e = W'(exp);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, e, $time);
    end
  endtask

  task automatic reset_model();
    n_edges = 0;
    va      = INIT_A;
    vb      = INIT_B;
  endtask

  // One rising edge, model update, then sample 50 ns later.
  task automatic edge_chk(input string tag);
    int d;
    @(posedge clk);
    d = cur_step();
    if (rst) begin
      reset_model();
    end else begin
      n_edges++;
      va = (va + d + MODV) % MODV;
      if (n_edges % PRE_B == 0) vb = (vb + d + MODV) % MODV;
    end
    #50;
    check({tag, "_a"}, bus_a.led, va);
    check({tag, "_b"}, bus_b.led, vb);
  endtask

  // Called mid-cycle (50 ns after an edge); pulse stays clear of the next edge.
  task automatic pulse_rst(input string tag, input int width_ns);
    rst = 1'b1;
    #1;
    check({tag, "_rst_a"}, bus_a.led, INIT_A);
    check({tag, "_rst_b"}, bus_b.led, INIT_B);
    #(width_ns);
    rst = 1'b0;
    reset_model();
  endtask

  initial begin
    set_dir(1'b0);

    // Power-up state with rst tied low.
    #1;
    check("powerup_a", bus_a.led, INIT_A);
    check("powerup_b", bus_b.led, INIT_B);

    // 63 edges from power-up: led_a = i mod 16, led_b steps every 3rd edge.
    for (int i = 1; i <= 63; i++) edge_chk("free");

    // Wrap after reset: 15 -> 0 -> 1.
    pulse_rst("wrap", 20);
    for (int i = 1; i <= 17; i++) edge_chk("wrap");

    // Async reset mid-count at led=9.
    while (va != 9) edge_chk("to9");
    pulse_rst("mid", 10);
    edge_chk("after_mid");

    // Reset held across three edges, then released.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) edge_chk("hold");
    rst = 1'b0;
    reset_model();
    for (int i = 0; i < 7; i++) edge_chk("restart");

`ifdef TOP_COUNTER_DIR_EN
    // Down-count from reset, then back up.
    pulse_rst("dir", 15);
    set_dir(1'b1);
    edge_chk("down1");
    edge_chk("down2");
    set_dir(1'b0);
    edge_chk("up1");
    edge_chk("up2");
`endif

    // Random mix of count edges, short reset pulses and held resets.
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if ($urandom_range(0, 3) == 0) set_dir(1'($urandom_range(0, 1)));
      if (r == 0) begin
        pulse_rst("rnd", $urandom_range(1, 40));
      end else if (r == 1 && !rst) begin
        rst = 1'b1;
      end else if (rst && r > 10) begin
        rst = 1'b0;
        reset_model();
      end
      edge_chk("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/top_counter.md
Name: top_counter

Overview:
- Free-running binary counter driving an LED bank; the top-level design for the counter board test.
- Advances once per rising edge of clk by default. The count is presented directly as a registered output on led.
- Used as the install/smoke test for the FPGA flow, and runs both as a post-place-and-route timing-annotated netlist and as RTL.

Parameters:
- WIDTH, 4, counter and led width in bits (must be >= 1).
- INIT, 0, count value at power-up and after reset (WIDTH bits).
- PRESCALE, 1, clock cycles per count step (>= 1); 1 means one step every clk rising edge.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; tie to 0 when unused.
- led  output WIDTH  current count value, driven straight from the count register (no output logic).
- dir  input  1  count direction; present only when TOP_COUNTER_DIR_EN is defined.

Behaviour:
- Reset is asynchronous and active-high:
  - rst=1 immediately forces the count register to INIT and the prescaler to 0, independent of clk.
  - While rst=1, led holds INIT.
  - Counting resumes on the first clk rising edge after rst deasserts; no synchronous reset path.
- Power-up: the count register and prescaler carry initial values INIT and 0, so the design counts correctly without any rst pulse (rst tied low).
- Step generation:
  - The prescaler counts 0..PRESCALE-1. A step occurs on the rising edge where the prescaler equals PRESCALE-1, and the prescaler wraps to 0 on that edge.
  - With PRESCALE=1 the prescaler is omitted and every rising edge is a step.
- Count update on a step: count <= count + 1 modulo 2^WIDTH.
  - Wrap-around 2^WIDTH-1 -> 0 is silent; no flag, no saturation.
- Latency:
  - led is registered and changes only on a clk rising edge (or asynchronously on rst).
  - After the k-th step edge following reset/power-up, led = (INIT + k) mod 2^WIDTH.
  - With defaults, after edge k: led = k mod 16 (edge 1 -> 1, edge 15 -> 15, edge 16 -> 0).
- Between steps, led is stable; no glitching outputs, since led is the flop output.
- rst asserted mid-count: led returns to INIT at once, overriding any simultaneous clk edge.
- No other inputs; no enable.

Optional Feature:
- Macro TOP_COUNTER_DIR_EN.
- Defined:
  - Adds input dir. On each step, dir=0 increments and dir=1 decrements, modulo 2^WIDTH (0 -> 2^WIDTH-1 when decrementing).
  - dir is sampled on the step edge; changing dir between steps has no effect until the next step.
- Undefined:
  - No dir port; the counter always increments.
  - Port list is exactly clk, rst, led.

Decomposition:
- Package top_counter_pkg holds:
  - default constants COUNTER_WIDTH_DEF=4, COUNTER_INIT_DEF=0, COUNTER_PRESCALE_DEF=1;
  - a function computing the prescaler width, clog2(PRESCALE), minimum 1.
- One sub-module, top_counter_tick: the prescaler.
  - Ports clk, rst, tick output.
  - tick is high for one cycle every PRESCALE cycles; tied constant 1 when PRESCALE=1.
- The count register and next-value logic stay in top_counter.

Test Plan:
- Defaults, rst held low from time 0, clk period 200 ns. Check 50 ns after each of 63 rising edges -> led === i mod 16 for edge i (1,2,...,15,0,1,...,15), never X/Z.
- Wrap: run 15 edges from reset -> led=15; edge 16 -> led=0; edge 17 -> led=1.
- Async reset mid-count: at led=9, pulse rst between clock edges -> led=0 immediately, before the next edge; first edge after release -> led=1.
- Reset overlapping clk edge: hold rst=1 across 3 edges -> led stays 0 throughout; release -> counting restarts from 1.
- PRESCALE=3, INIT=5: after 3 edges led=6, after 6 edges led=7; led unchanged on the intermediate edges.
- TOP_COUNTER_DIR_EN, dir=1 from reset, defaults -> edge 1 led=15, edge 2 led=14. Switch dir=0 at led=14 -> next edge led=15, then 0.
